// File: rtl/opl_audio_dac_pkg.sv
// Shared constants and helpers for the OPL2 audio output stage.
// Samples are unsigned with 0x80 as the zero level.
package opl_audio_pkg;

    localparam logic [7:0] SILENCE        = 8'h80;
    localparam int         SAMPLE_DIV_48K = 1042;

    function automatic logic signed [7:0] to_signed8(input logic [7:0] x);
        return x ^ SILENCE;
    endfunction

endpackage

// File: rtl/opl_audio_dac_if.sv
// Firmware-facing sample/control/status bundle of the audio DAC.
// master = sample producer, slave = DAC.
interface opl_audio_dac_if #(
    parameter int FIFO_AW = 4
) ();

    logic [7:0]       sample_in;
    logic             sample_wr;
    logic [3:0]       vol;
    logic             mute;
    logic             stat_clr;
    logic [FIFO_AW:0] fifo_level;
    logic             fifo_full;
    logic             underrun;
    logic             overflow;
    logic             sample_tick;
    logic             audio_out;

    modport master (
        output sample_in, sample_wr, vol, mute, stat_clr,
        input  fifo_level, fifo_full, underrun, overflow,
        input  sample_tick, audio_out
    );

    modport slave (
        input  sample_in, sample_wr, vol, mute, stat_clr,
        output fifo_level, fifo_full, underrun, overflow,
        output sample_tick, audio_out
    );

endinterface

// File: rtl/opl_sample_fifo.sv
// Show-ahead sample FIFO with wrap-bit pointers.
// A write into a full FIFO is accepted only when a read frees a slot.
module opl_sample_fifo #(
    parameter int AW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          wr,
    input  logic [7:0]    wdata,
    input  logic          rd,
    output logic [7:0]    rdata,
    output logic [AW:0]   level,
    output logic          empty,
    output logic          full
);

    localparam int         DEPTH = 2 ** AW;
    localparam logic [AW:0] ONE  = 1;

    logic [AW:0] wp_q, rp_q;
    logic [7:0]  mem_q [DEPTH];
    logic        do_wr, do_rd;

    assign empty = (wp_q == rp_q);
    assign full  = (wp_q[AW] != rp_q[AW]) &&
                   (wp_q[AW-1:0] == rp_q[AW-1:0]);
    assign level = wp_q - rp_q;
    assign rdata = mem_q[rp_q[AW-1:0]];

    assign do_rd = rd & ~empty;
    assign do_wr = wr & (~full | do_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            wp_q <= '0;
            rp_q <= '0;
        end else begin
            if (do_wr) wp_q <= wp_q + ONE;
            if (do_rd) rp_q <= rp_q + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wp_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/opl_audio_dac.sv
// OPL2 audio output: sample FIFO, rate divider, volume/mute gain
// and a first-order sigma-delta modulator driving a 1-bit pin.
module opl_audio_dac
    import opl_audio_pkg::*;
#(
    parameter int SAMPLE_DIV = SAMPLE_DIV_48K,
    parameter int FIFO_AW    = 4
) (
    input  logic            clk,
    input  logic            rst,
    opl_audio_dac_if.slave  bus
);

    localparam logic [15:0] DIV_LAST = 16'(SAMPLE_DIV - 1);

    logic [15:0]      div_q, div_d;
    logic [7:0]       cur_q, cur_d;
    logic [7:0]       dac_val_q, dac_val_d;
    logic [8:0]       acc_q, acc_d;
    logic             und_q, und_d;
    logic             ovf_q, ovf_d;
    logic             tick, pop;
    logic [7:0]       rdata;
    logic [FIFO_AW:0] level;
    logic             empty, full;
    logic signed [7:0]  s;
    logic signed [11:0] p;
    logic signed [7:0]  g;
    logic [7:0]         gain_val;

    assign tick = (div_q == DIV_LAST);
    assign pop  = tick & ~empty;

    opl_sample_fifo #(.AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr    (bus.sample_wr),
        .wdata (bus.sample_in),
        .rd    (tick),
        .rdata (rdata),
        .level (level),
        .empty (empty),
        .full  (full)
    );

    always_comb begin
        div_d    = tick ? '0 : div_q + 16'd1;
        cur_d    = pop ? rdata : cur_q;
        // gain is applied to the sample being loaded so dac_val is valid at T+1
        s        = to_signed8(cur_d);
        p        = 12'(s) * 12'($signed({1'b0, bus.vol}));
        g        = 8'(p >>> 4);
        gain_val = bus.mute ? SILENCE : (g ^ SILENCE);
        dac_val_d = tick ? gain_val : dac_val_q;
        und_d    = (tick & empty) | (und_q & ~bus.stat_clr);
        ovf_d    = (bus.sample_wr & full & ~pop) |
                   (ovf_q & ~bus.stat_clr);
        acc_d    = {1'b0, acc_q[7:0]} + {1'b0, dac_val_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            div_q     <= '0;
            cur_q     <= SILENCE;
            dac_val_q <= SILENCE;
            acc_q     <= '0;
            und_q     <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            div_q     <= div_d;
            cur_q     <= cur_d;
            dac_val_q <= dac_val_d;
            acc_q     <= acc_d;
            und_q     <= und_d;
            ovf_q     <= ovf_d;
        end
    end

    assign bus.fifo_level  = level;
    assign bus.fifo_full   = full;
    assign bus.underrun    = und_q;
    assign bus.overflow    = ovf_q;
    assign bus.sample_tick = tick;
    assign bus.audio_out   = acc_q[8];

endmodule

// File: tb/tb_opl_audio_dac.sv
// Bench for opl_audio_dac: directed steps, queue scoreboard of written
// samples, cycle model of divider/flags/gain/modulator checked every cycle.
module tb_opl_audio_dac;

    localparam int DIV = 32;
    localparam int AW  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk  = 0;
    int   n_fail = 0;

    always #5 clk = ~clk;

    opl_audio_dac_if #(.FIFO_AW(AW)) bus ();

    opl_audio_dac #(.SAMPLE_DIV(DIV), .FIFO_AW(AW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // reference model state
    logic [7:0] mq [$];
    int         m_div   = 0;
    logic [7:0] m_cur   = 8'h80;
    logic [7:0] m_dac   = 8'h80;
    logic [8:0] m_acc   = '0;
    logic       m_und   = 1'b0;
    logic       m_ovf   = 1'b0;

    function automatic logic [7:0] exp_gain(input logic [7:0] smp,
                                            input logic [3:0] v,
                                            input logic m);
        int sv, pr, gv;
        if (m) return 8'h80;
        sv = int'(smp) - 128;
        pr = sv * int'(v);
        gv = (pr >= 0) ? pr / 16 : -((-pr + 15) / 16);
        return 8'(gv + 128);
    endfunction

    always @(posedge clk) begin
        bit tk, pp, fl, nu, no, wok;
        if (rst) begin
            mq.delete();
            m_div = 0;
            m_cur = 8'h80;
            m_dac = 8'h80;
            m_acc = '0;
            m_und = 1'b0;
            m_ovf = 1'b0;
        end else begin
            tk  = (m_div == DIV - 1);
            pp  = tk && (mq.size() > 0);
            nu  = tk && (mq.size() == 0);
            fl  = (mq.size() == 2 ** AW);
            wok = bus.sample_wr && (!fl || pp);
            no  = bus.sample_wr && fl && !pp;
            m_acc = {1'b0, m_acc[7:0]} + {1'b0, m_dac};
            if (pp) m_cur = mq.pop_front();
            if (tk) m_dac = exp_gain(m_cur, bus.vol, bus.mute);
            if (wok) mq.push_back(bus.sample_in);
            m_und = nu || (m_und && !bus.stat_clr);
            m_ovf = no || (m_ovf && !bus.stat_clr);
            m_div = tk ? 0 : m_div + 1;
        end
    end

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("level",    16'(bus.fifo_level), 16'(mq.size()));
        chk("full",     16'(bus.fifo_full),  16'(mq.size() == 2 ** AW));
        chk("underrun", 16'(bus.underrun),   16'(m_und));
        chk("overflow", 16'(bus.overflow),   16'(m_ovf));
        chk("tick",     16'(bus.sample_tick), 16'(m_div == DIV - 1));
        chk("audio",    16'(bus.audio_out),  16'(m_acc[8]));
        chk("dac",      16'(dut.dac_val_q),  16'(m_dac));
    endtask

    task automatic step();
        @(negedge clk);
        check_all();
    endtask

    task automatic wait_tick();
        int k;
        k = 0;
        while (!bus.sample_tick && k < 4 * DIV) begin
            step();
            k++;
        end
        chk("tick_wait", 16'(bus.sample_tick), 16'd1);
    endtask

    task automatic play_tick();
        wait_tick();
        step();
    endtask

    task automatic write(input logic [7:0] v);
        bus.sample_in = v;
        bus.sample_wr = 1'b1;
        step();
        bus.sample_wr = 1'b0;
    endtask

    task automatic clr();
        bus.stat_clr = 1'b1;
        step();
        bus.stat_clr = 1'b0;
    endtask

    task automatic density(output int ones);
        ones = 0;
        repeat (256) begin
            step();
            ones += int'(bus.audio_out);
        end
    endtask

    initial begin
        int ones;
        bus.sample_in = '0;
        bus.sample_wr = 1'b0;
        bus.vol       = 4'd15;
        bus.mute      = 1'b0;
        bus.stat_clr  = 1'b0;
        repeat (3) step();
        chk("rst_level", 16'(bus.fifo_level), 16'd0);
        chk("rst_full",  16'(bus.fifo_full),  16'd0);
        chk("rst_und",   16'(bus.underrun),   16'd0);
        chk("rst_ovf",   16'(bus.overflow),   16'd0);
        chk("rst_tick",  16'(bus.sample_tick), 16'd0);
        chk("rst_audio", 16'(bus.audio_out),  16'd0);
        chk("rst_dac",   16'(dut.dac_val_q),  16'h80);
        rst = 1'b0;

        // 1) idle: underrun after first tick, 50% density
        repeat (DIV - 2) step();
        chk("t1_no_tick_early", 16'(bus.sample_tick), 16'd0);
        step();
        chk("t1_first_tick", 16'(bus.sample_tick), 16'd1);
        step();
        chk("t1_underrun", 16'(bus.underrun), 16'd1);
        chk("t1_level", 16'(bus.fifo_level), 16'd0);
        density(ones);
        chk("t1_density", 16'(ones), 16'd128);
        clr();

        // 2) full-scale sample at vol 15
        write(8'hFF);
        play_tick();
        chk("t2_dac", 16'(dut.dac_val_q), 16'hF7);
        density(ones);
        chk("t2_density", 16'(ones), 16'd247);

        // 3) 17 writes without a tick, then drain in order
        wait_tick();
        step();
        clr();
        for (int i = 0; i < 17; i++)
            write(i < 16 ? 8'(i * 16 + 8) : 8'hEE);
        chk("t3_level", 16'(bus.fifo_level), 16'd16);
        chk("t3_full",  16'(bus.fifo_full),  16'd1);
        chk("t3_ovf",   16'(bus.overflow),   16'd1);
        chk("t3_und",   16'(bus.underrun),   16'd0);
        for (int i = 0; i < 16; i++) begin
            play_tick();
            chk("t3_pop", 16'(dut.dac_val_q),
                16'(exp_gain(8'(i * 16 + 8), 4'd15, 1'b0)));
        end
        chk("t3_und_before", 16'(bus.underrun), 16'd0);
        play_tick();
        chk("t3_und_after", 16'(bus.underrun), 16'd1);

        // 4) write into full FIFO in the tick cycle
        clr();
        wait_tick();
        step();
        for (int i = 0; i < 16; i++)
            write(8'(8'h30 + i * 8));
        chk("t4_full", 16'(bus.fifo_full), 16'd1);
        wait_tick();
        write(8'h5A);
        chk("t4_ovf",   16'(bus.overflow),   16'd0);
        chk("t4_level", 16'(bus.fifo_level), 16'd16);
        for (int i = 0; i < 16; i++) play_tick();
        chk("t4_last", 16'(dut.dac_val_q),
            16'(exp_gain(8'h5A, 4'd15, 1'b0)));

        // 5) negative full scale at half volume, mute, zero volume
        bus.vol = 4'd8;
        write(8'h00);
        play_tick();
        chk("t5_vol8", 16'(dut.dac_val_q), 16'h40);
        bus.mute = 1'b1;
        write(8'h00);
        play_tick();
        chk("t5_mute", 16'(dut.dac_val_q), 16'h80);
        bus.mute = 1'b0;
        bus.vol  = 4'd0;
        write(8'h00);
        play_tick();
        chk("t5_vol0", 16'(dut.dac_val_q), 16'h80);
        bus.vol = 4'd15;

        // 6) mid-stream reset discards queued samples
        clr();
        for (int i = 0; i < 5; i++) write(8'(8'hC0 + i));
        chk("t6_level_pre", 16'(bus.fifo_level), 16'd5);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t6_level", 16'(bus.fifo_level), 16'd0);
        chk("t6_audio", 16'(bus.audio_out),  16'd0);
        chk("t6_dac",   16'(dut.dac_val_q),  16'h80);
        chk("t6_und0",  16'(bus.underrun),   16'd0);
        play_tick();
        chk("t6_und1",  16'(bus.underrun),   16'd1);
        chk("t6_dac_hold", 16'(dut.dac_val_q), 16'h80);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
